// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) drives grants.
interface rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic               preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: grant is registered, so it appears one edge after the request is seen; each handover costs one dead cycle.
// Backpressure: an owner keeps the grant while its req stays high; RR_ARB_HOLD_LIMIT_EN adds hold-limit preemption after MAX_HOLD cycles.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W != $clog2(NUM_REQ) ||
        MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("rr_arbiter: illegal parameter combination");
    end

    state_t             state_q,     state_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]    gnt_id_q,    gnt_id_d;
    logic [ID_W-1:0]    ptr_q,       ptr_d;

    logic               req_any;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win_oh;
    logic               owner_req;
    logic               other_req;
    logic [ID_W-1:0]    ptr_next_owner;

    // Search order: ptr, ptr+1, ... wrapping at NUM_REQ-1 back to 0.
    always_comb begin
        int pos;
        req_any = 1'b0;
        win_id  = '0;
        pos     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr_q) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!req_any && bus.req[j] && (pos == j)) begin
                    req_any = 1'b1;
                    win_id  = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        win_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            win_oh[j] = (ID_W'(j) == win_id);
        end
    end

    assign owner_req      = |(bus.req & gnt_q);
    assign other_req      = |(bus.req & ~gnt_q);
    assign ptr_next_owner = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       preempt_q,  preempt_d;
    logic       hold_expired;

    assign hold_expired = (hold_cnt_q == HOLD_LAST);
`else
    logic       hold_expired;

    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = 1'b0;
`endif

        case (state_q)
            IDLE, RELEASE: begin
                if (req_any) begin
                    state_d     = GRANT;
                    gnt_d       = win_oh;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = win_id;
`ifdef RR_ARB_HOLD_LIMIT_EN
                    hold_cnt_d  = '0;
`endif
                end else begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                end
            end

            GRANT: begin
                // A voluntary drop and a forced release leave through the same dead slot.
                if (!owner_req || (hold_expired && other_req)) begin
                    state_d     = RELEASE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    ptr_d       = ptr_next_owner;
`ifdef RR_ARB_HOLD_LIMIT_EN
                    preempt_d   = owner_req;
`endif
                end
`ifdef RR_ARB_HOLD_LIMIT_EN
                else if (!hold_expired) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
`endif
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef RR_ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign bus.preempt = preempt_q;
`else
    assign bus.preempt = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: vector table plus hand-written reset, async-reset and hold-limit sequences.
// Expectations are queued when stimulus is driven and popped when the output is sampled.
module tb_rr_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ID_W     = 2;
    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       pre;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    vec_t  sb_q[$];
    string tag_q[$];
    vec_t  tbl[$];
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id, input logic pre);
        vec_t v;
        v.req = r;
        v.gnt = g;
        v.id  = id;
        v.pre = pre;
        return v;
    endfunction

    task automatic push_exp(input vec_t v, input string tag);
        sb_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check();
        vec_t  e;
        string t;
        logic  exp_vld;
        e       = sb_q.pop_front();
        t       = tag_q.pop_front();
        exp_vld = (e.gnt != 4'b0000);
        n_vec++;
        if (bus.gnt !== e.gnt || bus.gnt_id !== e.id || bus.gnt_valid !== exp_vld || bus.preempt !== e.pre) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b id=%0d vld=%b pre=%b, want gnt=%b id=%0d vld=%b pre=%b",
                     t, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt, e.gnt, e.id, exp_vld, e.pre);
        end
    endtask

    task automatic expect_after_edge(input vec_t v, input string tag);
        push_exp(v, tag);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic drive(input vec_t v, input string tag);
        @(negedge clk);
        bus.req = v.req;
        expect_after_edge(v, tag);
    endtask

    initial begin
        // Reset held with every request asserted.
        bus.req = 4'b1111;
        rst_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_after_edge(mk(4'b1111, 4'b0000, 2'd0, 1'b0), $sformatf("reset_hold[%0d]", i));
        end
        @(negedge clk);
        rst_n = 1'b1;
        expect_after_edge(mk(4'b1111, 4'b0001, 2'd0, 1'b0), "reset_first_grant");

        // Owner 0 holds; ptr = 0 from here.
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        // Single requester 2 for five cycles.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        // Requester 3 once so the pointer wraps back to 0.
        tbl.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        // Rotation 0,1,2,3,0 with each owner dropping after three grant cycles.
        for (int k = 0; k < 4; k++) begin
            logic [3:0] oh;
            logic [3:0] drop;
            oh   = 4'b0001 << k;
            drop = 4'b1111 & ~oh;
            for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b1111, oh, 2'(k), 1'b0));
            tbl.push_back(mk(drop, 4'b0000, 2'd0, 1'b0));
        end
        tbl.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1110, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        // Return ptr to 0, then the pointer-skip case.
        tbl.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1010, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b0));
        // Non-owner request change while granted has no effect.
        tbl.push_back(mk(4'b1001, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i], $sformatf("table[%0d] req=%b", i, tbl[i].req));
        end

        // Async reset mid-grant; ptr is 1 here, so a missing ptr reset shows as 0010 later.
        drive(mk(4'b1000, 4'b1000, 2'd3, 1'b0), "async_pre_grant");
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(mk(4'b1000, 4'b0000, 2'd0, 1'b0), "async_reset_immediate");
        check();
        @(negedge clk);
        bus.req = 4'b0011;
        rst_n   = 1'b1;
        expect_after_edge(mk(4'b0011, 4'b0001, 2'd0, 1'b0), "post_reset_ptr0");

`ifdef RR_ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 3; i++) drive(mk(4'b0011, 4'b0001, 2'd0, 1'b0), $sformatf("hold0[%0d]", i));
        drive(mk(4'b0011, 4'b0000, 2'd0, 1'b1), "preempt_owner0");
        for (int i = 0; i < 4; i++) drive(mk(4'b0011, 4'b0010, 2'd1, 1'b0), $sformatf("hold1[%0d]", i));
        drive(mk(4'b0011, 4'b0000, 2'd0, 1'b1), "preempt_owner1");
        drive(mk(4'b0011, 4'b0001, 2'd0, 1'b0), "regrant_owner0");
        for (int i = 0; i < 8; i++) drive(mk(4'b0001, 4'b0001, 2'd0, 1'b0), $sformatf("alone_hold[%0d]", i));
        drive(mk(4'b0011, 4'b0000, 2'd0, 1'b1), "preempt_on_new_req");
        drive(mk(4'b0000, 4'b0000, 2'd0, 1'b0), "idle_after_preempt");
`else
        for (int i = 0; i < 12; i++) drive(mk(4'b0011, 4'b0001, 2'd0, 1'b0), $sformatf("no_limit_hold[%0d]", i));
        drive(mk(4'b0000, 4'b0000, 2'd0, 1'b0), "no_limit_release");
`endif
        drive(mk(4'b0000, 4'b0000, 2'd0, 1'b0), "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Parameterised N-way round-robin arbiter with an FSM. It shares one resource (bus, memory port, shared datapath) between NUM_REQ requesters.
- Generalises the fixed two-requester grant scheme to N requesters with fair rotation.
- An owner keeps the grant while its request stays high. A one-cycle dead slot separates successive owners.
- Optional hold-limit preemption bounds how long one owner can block the others.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ID_W, 2: width of gnt_id; must equal ceil(log2(NUM_REQ)).
- MAX_HOLD, 16: maximum consecutive grant cycles before preemption; only used with RR_ARB_HOLD_LIMIT_EN; legal range 2..255.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserting it (low) clears all state immediately. Deassertion is synchronised externally.
- req, input, NUM_REQ: request vector; bit i belongs to requester i; level-sensitive.
- gnt, output, NUM_REQ: one-hot grant, registered; all-zero when no owner.
- gnt_valid, output, 1: high when gnt is non-zero; registered.
- gnt_id, output, ID_W: binary index of the current owner; 0 when gnt_valid is low.
- preempt, output, 1: one-cycle pulse when the hold limit forces a release; tied 0 without the macro.

Behaviour:
- Reset (reset low):
  - state = IDLE, gnt = 0, gnt_valid = 0, gnt_id = 0, preempt = 0, ptr = 0, hold_cnt = 0.
  - Takes effect asynchronously, including mid-grant.
- ptr is the priority pointer.
  - The search starts at index ptr, ascends, and wraps from NUM_REQ-1 to 0.
  - The first asserted req bit wins.
- States:
  - IDLE: if any req bit is set, latch the winner, set gnt/gnt_id/gnt_valid at this edge, and go to GRANT. Otherwise stay in IDLE.
  - GRANT:
    - If req[owner] = 1, stay in GRANT and hold gnt unchanged.
    - If req[owner] = 0, clear gnt at this edge, set ptr = (owner+1) mod NUM_REQ, and go to RELEASE.
  - RELEASE:
    - gnt stays all-zero for exactly this cycle.
    - The arbitration decision is made here exactly as in IDLE, using the updated ptr. If any req is set, go to GRANT; else go to IDLE.
  - Illegal or unreachable encoding: go to IDLE with gnt = 0.
- Latency:
  - A request sampled at edge t in IDLE gives gnt high after edge t.
  - Owner-to-owner handover costs exactly one dead cycle (RELEASE).
- Grant lines never overlap; at most one bit of gnt is high in any cycle.
- Requests that drop before being granted are simply not granted; nothing is queued.
- A req change in a non-owner bit during GRANT has no effect on gnt.
- Simultaneous requests are resolved purely by ptr order. ptr changes only on release, so each requester waits at most NUM_REQ-1 grants.
- ptr wraps: after owner NUM_REQ-1 releases, ptr = 0.

Optional Feature:
- Macro: RR_ARB_HOLD_LIMIT_EN.
- Defined:
  - hold_cnt (8 bits) resets to 0 on entry to GRANT and increments every GRANT cycle.
  - Preemption triggers when hold_cnt = MAX_HOLD-1, req[owner] is still 1, and any other req bit is 1. Then:
    - gnt clears at that edge.
    - preempt pulses for 1 cycle, aligned with the first RELEASE cycle.
    - ptr = owner+1.
    - The FSM goes to RELEASE.
  - If no other requester is pending, hold_cnt saturates at MAX_HOLD-1 and the owner keeps the grant. Preemption fires on the first cycle another request appears.
- Undefined:
  - No counter logic exists and preempt is constant 0.
  - The owner holds the grant indefinitely.

Test Plan:
- Reset: drive reset low with req = 1111 for 3 cycles, then release. Required: gnt = 0000, gnt_valid = 0, gnt_id = 0 throughout reset. The first edge after release gives gnt = 0001.
- Single requester: req = 0100 at edge 0, held 5 cycles, then 0000. Required: gnt = 0100, gnt_id = 2 after edge 0 for 5 cycles. gnt = 0000 after the drop edge, then IDLE.
- Rotation: req = 1111 continuously; each owner drops its bit 3 cycles after its grant and reasserts one cycle later. Required: grant order 0, 1, 2, 3, 0, with exactly one all-zero cycle between owners.
- Pointer skip: ptr = 0, req = 1010. Required: gnt = 0010 first. After it releases (req = 1000), gnt = 1000 after one dead cycle.
- Hold limit (macro on, MAX_HOLD = 4), part 1: req = 0011 held. Required: gnt = 0001 for 4 cycles, then a preempt pulse with a dead cycle, then gnt = 0010 for 4 cycles.
- Hold limit, part 2: req = 0001 alone. Required: gnt stays 0001 past 4 cycles with preempt = 0.
- Async reset mid-grant: gnt = 1000 in GRANT; pull reset low between clock edges. Required: gnt = 0000 and gnt_valid = 0 immediately, without a clock edge. After release, ptr = 0.
